// File: rtl/nav_pkg.sv
// Shared opcodes, one-hot selector codes and FSM state encoding for the
// navigation mode sequencer and its datapath selectors.
package nav_pkg;

  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_ZERO_POS = 3'd1;
  localparam logic [2:0] OP_HALT     = 3'd2;
  localparam logic [2:0] OP_ATTACK   = 3'd3;
  localparam logic [2:0] OP_DEFENSE  = 3'd4;
  localparam logic [2:0] OP_STEALTH  = 3'd5;
  localparam logic [2:0] OP_WARP     = 3'd6;
  localparam logic [2:0] OP_RSVD     = 3'd7;

  localparam logic [3:0] MODE_HALT    = 4'b0001;
  localparam logic [3:0] MODE_ATTACK  = 4'b0010;
  localparam logic [3:0] MODE_DEFENSE = 4'b0100;
  localparam logic [3:0] MODE_STEALTH = 4'b1000;

  localparam logic [3:0] POS_RESET  = 4'b0001;
  localparam logic [3:0] POS_NORMAL = 4'b0010;
  localparam logic [3:0] POS_WARP   = 4'b0100;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_CRUISE   = 3'd1,
    ST_ZERO     = 3'd2,
    ST_CHARGE   = 3'd3,
    ST_JUMP     = 3'd4,
    ST_COOLDOWN = 3'd5
  } nav_state_e;

  // Position selector is a pure function of the phase; 1000 is unreachable.
  function automatic logic [3:0] pos_for_state(input nav_state_e s);
    case (s)
      ST_INIT, ST_ZERO: return POS_RESET;
      ST_JUMP:          return POS_WARP;
      default:          return POS_NORMAL;
    endcase
  endfunction

endpackage

// File: rtl/nav_phase_counter.sv
// Loadable down-counter timing the warp CHARGE and COOLDOWN phases.
// Saturates at zero; zero flag is decoded from the register.
module nav_phase_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             cnt_zero
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_zero = (cnt_q == '0);

endmodule

// File: rtl/nav_mode_sequencer.sv
// Control FSM driving the one-hot mode/position selectors of the spatial
// position datapath; accepts pilot commands and sequences warps.
module nav_mode_sequencer
  import nav_pkg::*;
#(
  parameter int WARP_CHARGE = 8,
  parameter int WARP_COOL   = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_op,
  output logic       cmd_ready,
  input  logic       warp_abort,
  output logic [3:0] mode_selector,
  output logic [3:0] pos_selector,
  output logic       warp_active,
  output logic       cmd_err,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] CHARGE_LOAD = CNT_W'(WARP_CHARGE - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD   = CNT_W'(WARP_COOL - 1);

  nav_state_e       state_d, state_q;
  logic [3:0]       mode_d, mode_q;
  logic [3:0]       pos_d, pos_q;
  logic             cmd_ready_d, cmd_ready_q;
  logic             warp_active_d, warp_active_q;
  logic             cmd_err_d, cmd_err_q;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;
  logic             accept;

  nav_phase_counter #(.CNT_W(CNT_W)) u_phase_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .cnt_zero (cnt_zero)
  );

  assign accept = cmd_valid && cmd_ready_q;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statements can leave a value unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    cmd_err_d    = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = CHARGE_LOAD;
    cnt_dec      = 1'b0;

    case (state_q)
      ST_INIT: state_d = ST_CRUISE;
      ST_CRUISE: begin
        if (accept) begin
          case (cmd_op)
            OP_NOP:      ;
            OP_ZERO_POS: state_d = ST_ZERO;
            OP_HALT:     mode_d  = MODE_HALT;
            OP_ATTACK:   mode_d  = MODE_ATTACK;
            OP_DEFENSE:  mode_d  = MODE_DEFENSE;
            OP_STEALTH:  mode_d  = MODE_STEALTH;
            OP_WARP: begin
              if (mode_q == MODE_STEALTH) begin
                cmd_err_d = 1'b1;
              end else begin
                state_d  = ST_CHARGE;
                cnt_load = 1'b1;
              end
            end
            default:     cmd_err_d = 1'b1;
          endcase
        end
      end
      ST_ZERO: state_d = ST_CRUISE;
      ST_CHARGE: begin
        cnt_dec = 1'b1;
        // Abort wins over the count expiring and skips cooldown entirely.
        if (warp_abort) begin
          state_d = ST_CRUISE;
        end else if (cnt_zero) begin
          state_d = ST_JUMP;
        end
      end
      ST_JUMP: begin
        state_d      = ST_COOLDOWN;
        cnt_load     = 1'b1;
        cnt_load_val = COOL_LOAD;
      end
      ST_COOLDOWN: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          state_d = ST_CRUISE;
        end
      end
      default: state_d = ST_INIT;
    endcase

    // Outputs are decoded from the next state so they leave the flops aligned
    // with the phase they describe.
    pos_d         = pos_for_state(state_d);
    cmd_ready_d   = (state_d == ST_CRUISE);
    warp_active_d = (state_d == ST_CHARGE) || (state_d == ST_JUMP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_INIT;
      mode_q        <= MODE_HALT;
      pos_q         <= POS_RESET;
      cmd_ready_q   <= 1'b0;
      warp_active_q <= 1'b0;
      cmd_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      pos_q         <= pos_d;
      cmd_ready_q   <= cmd_ready_d;
      warp_active_q <= warp_active_d;
      cmd_err_q     <= cmd_err_d;
    end
  end

  assign mode_selector = mode_q;
  assign pos_selector  = pos_q;
  assign cmd_ready     = cmd_ready_q;
  assign warp_active   = warp_active_q;
  assign cmd_err       = cmd_err_q;
  assign phase         = state_q;

endmodule
